// File: rtl/spi_add_pkg.sv
// Shared types and sizing helpers for the SPI adder responder.
package spi_add_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RX1  = 3'd1,
        RX2  = 3'd2,
        TX   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int FRAME_BITS = 3 * DATA_W_DEF;

    // SCK cycles in one frame for a given operand width.
    function automatic int frame_bits(input int w);
        return 3 * w;
    endfunction

    // The bit counter runs 0 .. frame_bits-1 across the whole frame.
    function automatic int cnt_width(input int w);
        return $clog2(3 * w);
    endfunction

    localparam int CNT_W = cnt_width(DATA_W_DEF);

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with rise/fall detection on the synchronised value.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              q_d;

    // Shift the async input through the chain and keep one delayed copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RST_VAL}};
            q_d  <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            q_d  <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_add_slave.sv
// SPI mode-0 responder: receives two operands and returns their sum in the same CS frame.
//
// state | meaning
// IDLE  | waiting for CS to fall
// RX1   | shifting in operand 1
// RX2   | shifting in operand 2
// TX    | shifting the sum out on MISO, one bit per SCK fall
// DONE  | frame complete, SCK ignored until CS rises
module spi_add_slave
    import spi_add_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [DATA_W-1:0] data_o,
    output logic              carry_o,
    output logic              op_valid_o,
    output logic              frame_done_o,
    output logic              frame_err_o
);

    localparam int CW = cnt_width(DATA_W);
    localparam int FB = frame_bits(DATA_W);

    logic                   sck_s, sck_rise, sck_fall;
    logic [SYNC_STAGES-1:0] cs_sync, mosi_sync;
    logic                   cs_s, mosi_s, cs_d, cs_fall;
    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_W-1:0]      rx_sh, rx_next, tx_sh, data1_keep;
    logic [DATA_W:0]        sum;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk   (sclk),
        .rst_n (rst_n),
        .d     (spi_sck),
        .q     (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // CS resets to inactive so reset release never looks like a frame start.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_d      <= cs_s;
        end
    end

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign cs_fall = cs_d & ~cs_s;
    assign rx_next = {rx_sh[DATA_W-2:0], mosi_s};
    assign sum     = {1'b0, data1_o} + {1'b0, rx_next};

    // Frame sequencer. data1_keep holds the last committed operand 1 so an
    // abort during operand 2 can undo the early data1_o update.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_sh        <= '0;
            tx_sh        <= '0;
            data1_keep   <= '0;
            data1_o      <= '0;
            data2_o      <= '0;
            data_o       <= '0;
            carry_o      <= 1'b0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            op_valid_o   <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            op_valid_o   <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
            spi_miso_oe  <= ~cs_s;
            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall) begin
                        state   <= RX1;
                        bit_cnt <= '0;
                        rx_sh   <= '0;
                    end
                end
                RX1, RX2: begin
                    if (cs_s) begin
                        state       <= IDLE;
                        frame_err_o <= 1'b1;
                        spi_miso    <= 1'b0;
                        data1_o     <= data1_keep;
                    end else if (sck_rise) begin
                        rx_sh   <= rx_next;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (state == RX1 && bit_cnt == CW'(DATA_W - 1)) begin
                            data1_o <= rx_next;
                            state   <= RX2;
                        end else if (state == RX2 && bit_cnt == CW'(2 * DATA_W - 1)) begin
                            data2_o    <= rx_next;
                            data_o     <= sum[DATA_W-1:0];
                            carry_o    <= sum[DATA_W];
                            tx_sh      <= sum[DATA_W-1:0];
                            data1_keep <= data1_o;
                            op_valid_o <= 1'b1;
                            state      <= TX;
                        end
                    end
                end
                TX: begin
                    if (cs_s) begin
                        state       <= IDLE;
                        frame_err_o <= 1'b1;
                        spi_miso    <= 1'b0;
                    end else if (sck_fall) begin
                        spi_miso <= tx_sh[DATA_W-1];
                        tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
                    end else if (sck_rise) begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(FB - 1)) begin
                            state        <= DONE;
                            frame_done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (cs_s) begin
                        state    <= IDLE;
                        spi_miso <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
